event_arbiter: RTL
==================

// Module: event_arbiter
// PURPOSE
//  Collects up to N single-bit event signals that are already synchronized into the clk domain
//  (outputs of the edge_detector synchronizers).
//  Latches each rising edge as a pending request.
//  Round-robin schedules pending requests onto one shared consumer via a valid/ready handshake.
//  Sits between the bank of synchronizers and the single FSM that services events.
// PARAMETERS
//  N     4           number of event channels (2..16)
//  IDXW  $clog2(N)   width of evt_idx
// PORTS
//  clk           in   1     system clock; all state on posedge clk
//  reset_n       in   1     asynchronous, active-low reset
//  event_in      in   N     synchronized event levels, one per channel
//  evt_ready     in   1     consumer accepts the offered event this cycle
//  clr_overflow  in   1     synchronous clear of all overflow bits
//  evt_valid     out  1     an event is offered on evt_idx
//  evt_idx       out  IDXW  channel index of the offered event
//  pending       out  N     per-channel pending flags, including the one being offered
//  overflow      out  N     sticky: an edge arrived while that channel was already pending
// BEHAVIOUR
//  Reset (reset_n=0, asynchronous):
//   - evt_valid=0, evt_idx=0, pending=0, overflow=0.
//   - Edge history prev=0; state=IDLE; last_grant=N-1, so channel 0 has first priority.
//   - Reset asserted mid-offer drops evt_valid immediately. No event is delivered.
//  Edge detect:
//   - rise[i] = event_in[i] & ~prev[i]; prev <= event_in every cycle.
//   - Only 0->1 transitions count. A held-high input yields one event.
//  Pending and overflow, per channel i:
//   - take[i] = evt_valid & evt_ready & (evt_idx==i).
//   - rise & ~pending            -> pending set.
//   - take & ~rise               -> pending cleared.
//   - take & rise (same cycle)   -> pending stays 1 (new event queued); no overflow.
//   - rise & pending & ~take     -> pending stays 1; overflow[i] set. Events merge; none lost silently.
//   - clr_overflow clears all overflow bits. A same-cycle new overflow wins (bit ends at 1).
//  FSM, two states:
//   - IDLE: if any pending, pick the first set bit scanning last_grant+1, +2, ... modulo N (wraps N-1 -> 0).
//     Register evt_idx, set evt_valid=1, go to OFFER. Else stay in IDLE with evt_valid=0.
//   - OFFER: evt_valid=1; evt_idx held stable.
//     On evt_ready=1: last_grant<=evt_idx, evt_valid<=0, go to IDLE.
//     On evt_ready=0: remain in OFFER with no re-arbitration. A newly pending higher-priority channel waits.
//   - evt_ready while evt_valid=0 is ignored.
//  Timing:
//   - Latency: event_in rises before edge k -> pending set after edge k -> evt_valid=1 after edge k+1.
//   - Throughput: one event per 2 cycles minimum (mandatory IDLE bubble after each accept).
//  Widths: evt_idx is always < N; arbitration only considers indices < N when N is not a power of 2.
// TESTING
//  T1 reset: hold reset_n=0 while event_in=4'b1111 -> all outputs 0; release -> offers idx 0,1,2,3 in order.
//  T2 single: pulse event_in[2] for 1 cycle, evt_ready=1 -> evt_valid 2 cycles later, evt_idx=2;
//     pending[2] clears after the accept.
//  T3 round-robin: event_in=4'b1011 together, evt_ready=1 -> idx 0,1,3 with one idle cycle between.
//     Next fire of 0 and 1 after last_grant=3 -> idx 0 first.
//  T4 backpressure: evt_ready=0 for 10 cycles during an offer of idx 1 -> evt_valid and evt_idx=1 stable;
//     a new ch0 edge meanwhile is served after ch1.
//  T5 overflow: two edges on ch3 while evt_ready=0 -> overflow[3]=1, a single event delivered.
//     clr_overflow -> overflow=0. clr_overflow in the same cycle as a new overflow -> overflow stays 1.
//  T6 edge+take: ch0 edge in the same cycle its offer is accepted -> pending[0] stays 1, overflow[0]=0,
//     ch0 offered again.

Source files
------------

// File: rtl/event_arbiter_if.sv
// Offer/accept channel between the event arbiter and the single event consumer.
interface event_arbiter_if #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) ();
    logic            evt_valid;
    logic            evt_ready;
    logic [IDXW-1:0] evt_idx;

    modport master (output evt_valid, output evt_idx, input evt_ready);
    modport slave  (input evt_valid, input evt_idx, output evt_ready);
endinterface

// File: rtl/event_arbiter.sv
// Latches rising edges of synchronized event lines as pending requests and
// offers them one at a time, round-robin, to a single consumer.
module event_arbiter #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   event_in,
    input  logic           clr_overflow,
    event_arbiter_if.master bus,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   overflow
);

    typedef enum logic {IDLE, OFFER} state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [N-1:0]    prev_q;
    logic [N-1:0]    rise, take;
    logic [N-1:0]    pending_d, overflow_d;
    logic            grant_found;
    logic [IDXW-1:0] grant_idx;

    assign bus.evt_valid = (state_q == OFFER);
    assign bus.evt_idx   = idx_q;

    assign rise = event_in & ~prev_q;

    always_comb begin
        take = '0;
        if (bus.evt_valid && bus.evt_ready)
            take[idx_q] = 1'b1;
    end

    // A take and a new edge in the same cycle leave the channel pending without
    // counting as an overflow: the accepted event was the old one.
    assign pending_d  = (pending & ~take) | rise;
    assign overflow_d = (clr_overflow ? '0 : overflow) | (rise & pending & ~take);

    // Scan starts one past the last grant; only indices < N are ever visited.
    always_comb begin
        int c;
        c           = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(last_q) + k) % N;
            if (!grant_found && pending[c]) begin
                grant_found = 1'b1;
                grant_idx   = IDXW'(c);
            end
        end
    end

    // NOTE: every variable an always_comb assigns gets a default first, so no
    // path leaves it holding its old value and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    idx_d   = grant_idx;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (bus.evt_ready) begin
                    last_d  = idx_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= IDXW'(N - 1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q   <= '0;
            pending  <= '0;
            overflow <= '0;
        end else begin
            prev_q   <= event_in;
            pending  <= pending_d;
            overflow <= overflow_d;
        end
    end

endmodule
